// File: rtl/proc_pkg.sv
// Shared definitions for the processor control path.
// Holds the sequencer state codes, bus source and ALU op encodings, the
// control-word struct driven to the datapath, and a helper that identifies
// the states that complete an instruction.
package proc_pkg;

  localparam int ST_W = 6;
  typedef logic [ST_W-1:0] state_t;

  // Sequencer state codes
  localparam state_t ST_IDLE   = 6'd0;
  localparam state_t ST_FETCH1 = 6'd1;
  localparam state_t ST_FETCH2 = 6'd2;
  localparam state_t ST_FETCH3 = 6'd3;
  localparam state_t ST_LDR11  = 6'd4;
  localparam state_t ST_LDR12  = 6'd5;
  localparam state_t ST_LDR13  = 6'd6;
  localparam state_t ST_LDR14  = 6'd7;
  localparam state_t ST_LDR21  = 6'd8;
  localparam state_t ST_LDR22  = 6'd9;
  localparam state_t ST_LDR23  = 6'd10;
  localparam state_t ST_LDR24  = 6'd11;
  localparam state_t ST_STAC1  = 6'd12;
  localparam state_t ST_STAC2  = 6'd13;
  localparam state_t ST_STAC3  = 6'd14;
  localparam state_t ST_STAC4  = 6'd15;
  localparam state_t ST_ADD    = 6'd16;
  localparam state_t ST_ADD2   = 6'd17;
  localparam state_t ST_MUL    = 6'd18;

  // Bus source encodings
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_DR   = 3'd2;
  localparam logic [2:0] BUS_AC   = 3'd3;
  localparam logic [2:0] BUS_R1   = 3'd4;
  localparam logic [2:0] BUS_R2   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd6;

  // ALU op encodings (3 is reserved)
  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_MUL  = 2'd2;

  typedef struct packed {
    logic [2:0] bus_sel;
    logic       ld_ar;
    logic       ld_dr;
    logic       ld_ir;
    logic       ld_r1;
    logic       ld_r2;
    logic       ld_ac;
    logic       inc_pc;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] alu_op;
  } ctrl_word_t;

  // States that finish an instruction and bump the completion counter.
  function automatic logic is_terminal(state_t s);
    logic t;
    case (s)
      ST_LDR14, ST_LDR24, ST_STAC4, ST_ADD2, ST_MUL: t = 1'b1;
      default:                                       t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ctrl_rom.sv
// Combinational decode of a sequencer state into a datapath control word.
// Ports:
//   state_i  sequencer state code
//   ctrl_o   control word; all zero for idle and for undefined codes
module ctrl_rom
  import proc_pkg::*;
#(
  parameter int STATE_W = 6
) (
  input  logic [STATE_W-1:0] state_i,
  output ctrl_word_t         ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_t'(state_i))
      // Address phase: PC onto the bus, latch AR
      ST_FETCH1, ST_LDR11, ST_LDR21, ST_STAC1: begin
        ctrl_o.bus_sel = BUS_PC;
        ctrl_o.ld_ar   = 1'b1;
      end
      // Memory read into DR and step the PC
      ST_FETCH2, ST_LDR12, ST_LDR22, ST_STAC2: begin
        ctrl_o.mem_rd = 1'b1;
        ctrl_o.ld_dr  = 1'b1;
        ctrl_o.inc_pc = 1'b1;
      end
      ST_FETCH3: begin
        ctrl_o.bus_sel = BUS_DR;
        ctrl_o.ld_ir   = 1'b1;
      end
      // Operand address taken from DR
      ST_LDR13, ST_LDR23, ST_STAC3: begin
        ctrl_o.bus_sel = BUS_DR;
        ctrl_o.ld_ar   = 1'b1;
      end
      ST_LDR14: begin
        ctrl_o.mem_rd  = 1'b1;
        ctrl_o.bus_sel = BUS_MEM;
        ctrl_o.ld_r1   = 1'b1;
      end
      ST_LDR24: begin
        ctrl_o.mem_rd  = 1'b1;
        ctrl_o.bus_sel = BUS_MEM;
        ctrl_o.ld_r2   = 1'b1;
      end
      ST_STAC4: begin
        ctrl_o.bus_sel = BUS_AC;
        ctrl_o.mem_wr  = 1'b1;
      end
      ST_ADD: begin
        ctrl_o.bus_sel = BUS_R1;
        ctrl_o.alu_op  = ALU_PASS;
        ctrl_o.ld_ac   = 1'b1;
      end
      ST_ADD2: begin
        ctrl_o.bus_sel = BUS_R2;
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.ld_ac   = 1'b1;
      end
      ST_MUL: begin
        ctrl_o.bus_sel = BUS_R1;
        ctrl_o.alu_op  = ALU_MUL;
        ctrl_o.ld_ac   = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_decoder.sv
// Registers the decoded control word for the current sequencer state and
// keeps processor status: busy, halt pulse, saturating completed-instruction
// counter, sticky illegal-state flag and optional sticky sequence-check flag.
// Optional feature macro: CTRL_SEQ_CHECK_EN enables the transition checker
// behind seq_error; without it seq_error is constant 0.
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   state            sequencer state
//   bus_sel .. alu_op  registered control word (1 cycle after state)
//   busy, halted, instr_count, illegal_state, seq_error  status
module control_decoder
  import proc_pkg::*;
#(
  parameter int STATE_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  output logic [2:0]         bus_sel,
  output logic               ld_ar,
  output logic               ld_dr,
  output logic               ld_ir,
  output logic               ld_r1,
  output logic               ld_r2,
  output logic               ld_ac,
  output logic               inc_pc,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [1:0]         alu_op,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count,
  output logic               illegal_state,
  output logic               seq_error
);

  ctrl_word_t         rom_cw;
  ctrl_word_t         ctrl_q;
  logic [STATE_W-1:0] prev_state_q;
  logic               busy_q;
  logic               halted_q;
  logic               halted_d;
  logic               illegal_q;
  logic               illegal_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               state_changed;

  ctrl_rom #(.STATE_W(STATE_W)) u_rom (
    .state_i (state),
    .ctrl_o  (rom_cw)
  );

  assign state_changed = (state != prev_state_q);

  always_comb begin
    halted_d  = (prev_state_q == STATE_W'(ST_FETCH3)) && (state == STATE_W'(ST_IDLE));
    illegal_d = illegal_q || (state > STATE_W'(ST_MUL));
    count_d   = count_q;
    // A stalled terminal state counts only on entry; the counter saturates.
    if (is_terminal(state_t'(state)) && state_changed && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q       <= '0;
      prev_state_q <= '0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      ctrl_q       <= rom_cw;
      prev_state_q <= state;
      busy_q       <= (state != STATE_W'(ST_IDLE));
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      count_q      <= count_d;
    end
  end

`ifdef CTRL_SEQ_CHECK_EN
  logic chk_en_q;
  logic seq_err_q;
  logic legal_tr;

  // Legal moves: idle->fetch1, n->n+1 inside a non-terminal run,
  // fetch3->instruction entry points or idle, terminal->fetch1.
  always_comb begin
    legal_tr = 1'b0;
    if (!state_changed)
      legal_tr = 1'b1;
    else if (prev_state_q == STATE_W'(ST_IDLE))
      legal_tr = (state == STATE_W'(ST_FETCH1));
    else if (prev_state_q == STATE_W'(ST_FETCH3))
      legal_tr = (state == STATE_W'(ST_IDLE))  || (state == STATE_W'(ST_LDR11)) ||
                 (state == STATE_W'(ST_LDR21)) || (state == STATE_W'(ST_STAC1)) ||
                 (state == STATE_W'(ST_ADD))   || (state == STATE_W'(ST_MUL));
    else if (prev_state_q <= STATE_W'(ST_MUL)) begin
      if (is_terminal(state_t'(prev_state_q)))
        legal_tr = (state == STATE_W'(ST_FETCH1));
      else
        legal_tr = (state == prev_state_q + STATE_W'(1));
    end
  end

  // chk_en_q masks the first sample after reset, where prev_state is forced.
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_en_q  <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      chk_en_q  <= 1'b1;
      seq_err_q <= seq_err_q || (chk_en_q && !legal_tr);
    end
  end

  assign seq_error = seq_err_q;
`else
  assign seq_error = 1'b0;
`endif

  assign bus_sel       = ctrl_q.bus_sel;
  assign ld_ar         = ctrl_q.ld_ar;
  assign ld_dr         = ctrl_q.ld_dr;
  assign ld_ir         = ctrl_q.ld_ir;
  assign ld_r1         = ctrl_q.ld_r1;
  assign ld_r2         = ctrl_q.ld_r2;
  assign ld_ac         = ctrl_q.ld_ac;
  assign inc_pc        = ctrl_q.inc_pc;
  assign mem_rd        = ctrl_q.mem_rd;
  assign mem_wr        = ctrl_q.mem_wr;
  assign alu_op        = ctrl_q.alu_op;
  assign busy          = busy_q;
  assign halted        = halted_q;
  assign instr_count   = count_q;
  assign illegal_state = illegal_q;

endmodule

// File: tb/tb_control_decoder.sv
// Bench for control_decoder: a decode table drives a loop over all defined
// states, hand-written sequences cover stalls, halt, illegal codes, reset and
// counter saturation. Expected outputs are pushed to a queue when a state is
// driven and popped when the registered outputs are sampled.
module tb_control_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  state = 6'd0;
  logic [2:0]  bus_sel;
  logic        ld_ar, ld_dr, ld_ir, ld_r1, ld_r2, ld_ac;
  logic        inc_pc, mem_rd, mem_wr;
  logic [1:0]  alu_op;
  logic        busy, halted, illegal_state, seq_error;
  logic [15:0] instr_count;

  control_decoder #(.STATE_W(6), .CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .state         (state),
    .bus_sel       (bus_sel),
    .ld_ar         (ld_ar),
    .ld_dr         (ld_dr),
    .ld_ir         (ld_ir),
    .ld_r1         (ld_r1),
    .ld_r2         (ld_r2),
    .ld_ac         (ld_ac),
    .inc_pc        (inc_pc),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .alu_op        (alu_op),
    .busy          (busy),
    .halted        (halted),
    .instr_count   (instr_count),
    .illegal_state (illegal_state),
    .seq_error     (seq_error)
  );

  always #5 clock = ~clock;

  // Decode record; ld bits ordered ar,dr,ir,r1,r2,ac
  typedef struct packed {
    logic [5:0] st;
    logic [2:0] bus;
    logic [5:0] ld;
    logic       inc;
    logic       rd;
    logic       wr;
    logic [1:0] alu;
  } rec_t;

  typedef struct {
    logic [5:0]  st;
    logic [13:0] cw;
    logic        busy;
    logic        halted;
    logic [15:0] cnt;
    logic        ill;
    logic        seq;
  } exp_t;

  rec_t tbl [19];
  exp_t sb [$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [5:0]  m_prev;
  logic [15:0] m_cnt;
  logic        m_ill, m_seq, m_chk;

  function automatic logic [13:0] lookup(input logic [5:0] s);
    logic [13:0] cw;
    cw = '0;
    for (int i = 0; i < 19; i++)
      if (tbl[i].st == s) cw = {tbl[i].bus, tbl[i].ld, tbl[i].inc, tbl[i].rd, tbl[i].wr, tbl[i].alu};
    return cw;
  endfunction

  function automatic bit term(input logic [5:0] s);
    return (s == 7) || (s == 11) || (s == 15) || (s == 17) || (s == 18);
  endfunction

  function automatic bit legal(input logic [5:0] p, input logic [5:0] s);
    if (p == s) return 1'b1;
    case (p)
      6'd0:  return s == 1;
      6'd1:  return s == 2;
      6'd2:  return s == 3;
      6'd3:  return (s == 0) || (s == 4) || (s == 8) || (s == 12) || (s == 16) || (s == 18);
      6'd4:  return s == 5;
      6'd5:  return s == 6;
      6'd6:  return s == 7;
      6'd8:  return s == 9;
      6'd9:  return s == 10;
      6'd10: return s == 11;
      6'd12: return s == 13;
      6'd13: return s == 14;
      6'd14: return s == 15;
      6'd16: return s == 17;
      6'd7, 6'd11, 6'd15, 6'd17, 6'd18: return s == 1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_out(input bit verbose);
    exp_t e;
    logic [13:0] act_cw;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    act_cw = {bus_sel, ld_ar, ld_dr, ld_ir, ld_r1, ld_r2, ld_ac, inc_pc, mem_rd, mem_wr, alu_op};
    chk("ctrl_word", 32'(act_cw), 32'(e.cw));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("halted", 32'(halted), 32'(e.halted));
    chk("instr_count", 32'(instr_count), 32'(e.cnt));
    chk("illegal_state", 32'(illegal_state), 32'(e.ill));
    chk("seq_error", 32'(seq_error), 32'(e.seq));
    if (verbose)
      $display("tx st=%0d rst=%0b cw=%h busy=%0b halt=%0b cnt=%0d ill=%0b seq=%0b",
               e.st, reset, act_cw, busy, halted, instr_count, illegal_state, seq_error);
  endtask

  task automatic apply(input logic [5:0] s, input bit verbose);
    exp_t e;
    e.st     = s;
    e.cw     = lookup(s);
    e.busy   = (s != 0);
    e.halted = (m_prev == 3) && (s == 0);
    if (term(s) && (s != m_prev) && (m_cnt != 16'hFFFF)) m_cnt++;
    e.cnt = m_cnt;
    if (s > 18) m_ill = 1'b1;
    e.ill = m_ill;
`ifdef CTRL_SEQ_CHECK_EN
    if (m_chk && !legal(m_prev, s)) m_seq = 1'b1;
`endif
    e.seq  = m_seq;
    m_chk  = 1'b1;
    m_prev = s;
    sb.push_back(e);
    state = s;
    @(posedge clock);
    #1;
    compare_out(verbose);
  endtask

  task automatic do_reset(input int n, input logic [5:0] s);
    exp_t e;
    reset = 1'b1;
    state = s;
    m_prev = 6'd0; m_cnt = '0; m_ill = 1'b0; m_seq = 1'b0; m_chk = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.st = s; e.cw = '0; e.busy = 1'b0; e.halted = 1'b0;
      e.cnt = '0; e.ill = 1'b0; e.seq = 1'b0;
      sb.push_back(e);
      @(posedge clock);
      #1;
      compare_out(1'b1);
    end
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{6'd0,  3'd0, 6'b000000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{6'd1,  3'd1, 6'b100000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{6'd2,  3'd0, 6'b010000, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[3]  = '{6'd3,  3'd2, 6'b001000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[4]  = '{6'd4,  3'd1, 6'b100000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[5]  = '{6'd5,  3'd0, 6'b010000, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[6]  = '{6'd6,  3'd2, 6'b100000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{6'd7,  3'd6, 6'b000100, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[8]  = '{6'd8,  3'd1, 6'b100000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{6'd9,  3'd0, 6'b010000, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[10] = '{6'd10, 3'd2, 6'b100000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[11] = '{6'd11, 3'd6, 6'b000010, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[12] = '{6'd12, 3'd1, 6'b100000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[13] = '{6'd13, 3'd0, 6'b010000, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[14] = '{6'd14, 3'd2, 6'b100000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[15] = '{6'd15, 3'd3, 6'b000000, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[16] = '{6'd16, 3'd4, 6'b000001, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[17] = '{6'd17, 3'd5, 6'b000001, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[18] = '{6'd18, 3'd4, 6'b000001, 1'b0, 1'b0, 1'b0, 2'd2};

    // Reset held with a mid-instruction state on the bus
    do_reset(2, 6'd5);

    // Every defined state in code order
    for (int i = 0; i < 19; i++) apply(tbl[i].st, 1'b1);

    // Fetch then add/add2 back to fetch1
    do_reset(1, 6'd0);
    apply(6'd0, 1'b1); apply(6'd1, 1'b1); apply(6'd2, 1'b1); apply(6'd3, 1'b1);
    apply(6'd16, 1'b1); apply(6'd17, 1'b1); apply(6'd1, 1'b1);

    // Store with stac4 stalled 3 cycles: strobe repeats, counts once
    apply(6'd2, 1'b1); apply(6'd3, 1'b1); apply(6'd12, 1'b1);
    apply(6'd13, 1'b1); apply(6'd14, 1'b1);
    for (int i = 0; i < 3; i++) apply(6'd15, 1'b1);

    // Halt twice, with idle held between
    apply(6'd1, 1'b1); apply(6'd2, 1'b1); apply(6'd3, 1'b1); apply(6'd0, 1'b1);
    apply(6'd0, 1'b1); apply(6'd1, 1'b1); apply(6'd2, 1'b1); apply(6'd3, 1'b1);
    apply(6'd0, 1'b1); apply(6'd0, 1'b1);

    // Undefined code, then recovery only through reset
    apply(6'd40, 1'b1); apply(6'd0, 1'b1); apply(6'd1, 1'b1); apply(6'd63, 1'b1);
    apply(6'd19, 1'b1);
    do_reset(1, 6'd17);
    apply(6'd0, 1'b1);

    // Mid-instruction reset with a terminal state on the bus
    apply(6'd1, 1'b1); apply(6'd2, 1'b1);
    do_reset(1, 6'd17);
    apply(6'd17, 1'b1);

    // Skipped step: fetch1 -> fetch3
    do_reset(1, 6'd0);
    apply(6'd0, 1'b1); apply(6'd1, 1'b1); apply(6'd3, 1'b1); apply(6'd1, 1'b1);
    apply(6'd2, 1'b1);

    // First sample after reset is exempt from the sequence check
    do_reset(1, 6'd0);
    apply(6'd5, 1'b1); apply(6'd6, 1'b1); apply(6'd7, 1'b1);

    // Counter saturation: alternate two terminal states
    do_reset(1, 6'd0);
    for (int i = 0; i < 65535; i++) apply((i % 2 == 0) ? 6'd17 : 6'd18, 1'b0);
    $display("tx preload done cnt=%0d", instr_count);
    apply(6'd18, 1'b1); apply(6'd1, 1'b1); apply(6'd18, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
